// File: rtl/button_debounce_counter_if.sv
// button_debounce_counter_if: button, clear and status signals between the board/host and the debouncer.
interface button_debounce_counter_if;
  logic        button_n;
  logic        clear;
  logic [15:0] status;
  logic        press_pulse;
  logic        release_pulse;
  modport master (output button_n, clear, input status, press_pulse, release_pulse);
  modport slave (input button_n, clear, output status, press_pulse, release_pulse);
endinterface

// File: rtl/button_debounce_counter.sv
// button_debounce_counter: synchronise and debounce an active-low button, strobe press/release,
// and keep a saturating press count with sticky overflow for the host status word.
module button_debounce_counter #(
  parameter int DEBOUNCE_CYCLES = 960000,
  parameter int EVENT_W = 12
) (
  input logic ti_clk,
  input logic rst_n,
  button_debounce_counter_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {RELEASED = 2'b00, WAIT_PRESS = 2'b01, PRESSED = 2'b10, WAIT_RELEASE = 2'b11} state_t;
  state_t state_q;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic [EVENT_W-1:0] count_q, count_d;
  logic ovf_q, ovf_d, clear_q, press_q, release_q;
  logic sync_n, hit, commit, clear_rise;
  assign sync_n = sync_q[1];
  assign hit = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  assign commit = state_q == WAIT_PRESS && !sync_n && hit;
  assign clear_rise = bus.clear & ~clear_q;
  // A clear on the commit edge is applied first, so that press still counts.
  always_comb begin
    count_d = clear_rise ? '0 : count_q;
    ovf_d = clear_rise ? 1'b0 : ovf_q;
    if (commit) begin
      ovf_d = ovf_d | (&count_d);
      count_d = (&count_d) ? count_d : count_d + 1'b1;
    end
  end
  always_ff @(posedge ti_clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= 2'b11;
      clear_q <= 1'b1;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.button_n};
      clear_q <= bus.clear;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  always_ff @(posedge ti_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q <= '0;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        RELEASED: if (!sync_n) begin
          state_q <= WAIT_PRESS;
          cnt_q <= CW'(1);
        end
        WAIT_PRESS: if (sync_n) begin
          state_q <= RELEASED;
          cnt_q <= '0;
        end else if (hit) begin
          state_q <= PRESSED;
          cnt_q <= '0;
          press_q <= 1'b1;
        end else cnt_q <= cnt_q + CW'(1);
        PRESSED: if (sync_n) begin
          state_q <= WAIT_RELEASE;
          cnt_q <= CW'(1);
        end
        WAIT_RELEASE: if (!sync_n) begin
          state_q <= PRESSED;
          cnt_q <= '0;
        end else if (hit) begin
          state_q <= RELEASED;
          cnt_q <= '0;
          release_q <= 1'b1;
        end else cnt_q <= cnt_q + CW'(1);
        default: state_q <= RELEASED;
      endcase
    end
  assign bus.status = {count_q, state_q, ovf_q, state_q[1]};
  assign bus.press_pulse = press_q;
  assign bus.release_pulse = release_q;
endmodule

// File: tb/tb_button_debounce_counter.sv
// tb_button_debounce_counter: directed steps with a pulse scoreboard on a DEBOUNCE_CYCLES=8 instance,
// plus a DEBOUNCE_CYCLES=2 instance used for the 4096-press overflow and held-clear checks.
module tb_button_debounce_counter;
  typedef struct {bit press; int cyc; logic [15:0] st;} exp_t;
  logic ti_clk, rst_n, rst_f_n;
  int cyc, n_tests, n_fail, npf;
  bit prev_p;
  exp_t sb[$];
  exp_t e;
  button_debounce_counter_if bus();
  button_debounce_counter_if busf();
  button_debounce_counter #(.DEBOUNCE_CYCLES(8), .EVENT_W(12)) dut (.ti_clk(ti_clk), .rst_n(rst_n), .bus(bus));
  button_debounce_counter #(.DEBOUNCE_CYCLES(2), .EVENT_W(12)) dut_f (.ti_clk(ti_clk), .rst_n(rst_f_n), .bus(busf));
  initial ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;
  always @(posedge ti_clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge ti_clk);
    #1;
  endtask
  task automatic push(bit p, logic [15:0] st);
    sb.push_back('{p, cyc + 10, st});
  endtask
  task automatic flood_press();
    busf.button_n = 1'b0;
    step(3);
    busf.button_n = 1'b1;
    step(3);
  endtask
  always @(negedge ti_clk) begin
    if (bus.press_pulse || bus.release_pulse) begin
      chk("pulse_gap", {31'b0, prev_p}, 0);
      chk("pulse_both", {31'b0, bus.press_pulse & bus.release_pulse}, 0);
      if (sb.size() == 0) chk("unexpected_pulse", {30'b0, bus.press_pulse, bus.release_pulse}, 0);
      else begin
        e = sb.pop_front();
        chk("pulse_kind", {31'b0, bus.press_pulse}, {31'b0, e.press});
        chk("pulse_edge", cyc, e.cyc);
        chk("pulse_status", {16'b0, bus.status}, {16'b0, e.st});
      end
    end
    prev_p = bus.press_pulse | bus.release_pulse;
    if (busf.press_pulse) npf++;
  end
  initial begin
    cyc = 0; n_tests = 0; n_fail = 0; npf = 0; prev_p = 0;
    rst_n = 0; rst_f_n = 0;
    bus.button_n = 1; bus.clear = 0; busf.button_n = 1; busf.clear = 0;
    step(3);
    chk("reset_status", {16'b0, bus.status}, 0);
    chk("reset_pulses", {30'b0, bus.press_pulse, bus.release_pulse}, 0);
    rst_n = 1; rst_f_n = 1;
    step(50);
    chk("idle_status", {16'b0, bus.status}, 0);
    chk("idle_no_pulse", {31'b0, prev_p}, 0);
    // clean press and release
    bus.button_n = 0; push(1, 16'h0019); step(15);
    chk("pressed_status", {16'b0, bus.status}, 32'h0019);
    bus.button_n = 1; push(0, 16'h0010); step(15);
    chk("released_status", {16'b0, bus.status}, 32'h0010);
    // bounce: 5 low, 3 high, 7 low, then high - never commits
    bus.button_n = 0; step(5);
    bus.button_n = 1; step(3);
    bus.button_n = 0; step(7);
    bus.button_n = 1; step(20);
    chk("bounce_status", {16'b0, bus.status}, 32'h0010);
    // clear rises on the very edge the press commits
    bus.button_n = 0; push(1, 16'h0019); step(9);
    bus.clear = 1; step(5);
    chk("clear_commit", {16'b0, bus.status}, 32'h0019);
    bus.clear = 0; bus.button_n = 1; push(0, 16'h0010); step(15);
    chk("clear_commit_rel", {16'b0, bus.status}, 32'h0010);
    // reset during the 4th cycle of WAIT_PRESS
    bus.button_n = 0; step(6);
    rst_n = 0; #1;
    chk("async_rst_status", {16'b0, bus.status}, 0);
    chk("async_rst_pulses", {30'b0, bus.press_pulse, bus.release_pulse}, 0);
    step(2);
    rst_n = 1; push(1, 16'h0019); step(15);
    chk("post_rst_press", {16'b0, bus.status}, 32'h0019);
    bus.button_n = 1; push(0, 16'h0010); step(15);
    chk("post_rst_release", {16'b0, bus.status}, 32'h0010);
    chk("sb_empty", sb.size(), 0);
    // saturation on the fast instance
    for (int i = 0; i < 4095; i++) flood_press();
    step(5);
    chk("flood_4095_status", {16'b0, busf.status}, 32'hFFF0);
    chk("flood_4095_pulses", npf, 4095);
    flood_press();
    step(5);
    chk("flood_4096_status", {16'b0, busf.status}, 32'hFFF2);
    chk("flood_4096_pulses", npf, 4096);
    // held clear fires once only
    busf.clear = 1; step(1);
    chk("clear_rise", {16'b0, busf.status}, 0);
    flood_press();
    step(5);
    chk("clear_held_once", {16'b0, busf.status}, 32'h0010);
    step(8);
    chk("clear_held_end", {16'b0, busf.status}, 32'h0010);
    busf.clear = 0; step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
